// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// ----------------
// Shares the single unified instruction/data memory port between the fetch
// stage (F) and the memory stage (D). Only one transaction is outstanding at
// a time: the selected request is latched into the mem_* registers, presented
// with a req/gnt handshake, and completed by mem_rvalid.
//
// Optional build macro: MEMARB_ROUND_ROBIN_EN
//   undefined : fixed priority, data requester wins over fetch.
//   defined   : a last_served flag (reset = D) alternates the winner when
//               both requesters are pending at the same time.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   if_req/if_addr               fetch request (level, held until if_valid)
//   if_rdata/if_valid            fetch response (if_valid is a 1-cycle pulse)
//   d_req/d_we/d_addr/
//   d_wdata/d_wstrb              data request (level, held until d_valid)
//   d_rdata/d_valid              data response (d_valid is a 1-cycle pulse)
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_wstrb          registered memory request fields
//   mem_gnt/mem_rvalid/mem_rdata memory handshake and response
//   stall_fetch/stall_mem        per-stage stall requests to hazard logic
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_valid,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_fetch,
    output logic                  stall_mem
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_GNT = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_t;

    localparam logic OWNER_F = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t              state_r, state_s;
    logic                owner_r, owner_s;
    logic                mem_req_r, mem_req_s;
    logic                mem_we_r, mem_we_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic [DATA_W-1:0]   mem_wdata_r, mem_wdata_s;
    logic [STRB_W-1:0]   mem_wstrb_r, mem_wstrb_s;
    logic                pick_d_s;
    logic                rsp_done_s;

    // A response only counts while a transaction is waiting for it.
    assign rsp_done_s = (state_r == ST_WAIT_RSP) && mem_rvalid;

`ifdef MEMARB_ROUND_ROBIN_EN
    logic last_served_r;

    // Winner selection: on contention, serve whoever was not served last.
    always_comb begin
        pick_d_s = d_req && (!if_req || (last_served_r == OWNER_F));
    end

    // Remember which requester completed most recently.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_served_r <= OWNER_D;
        end else if (rsp_done_s) begin
            last_served_r <= owner_r;
        end else begin
            last_served_r <= last_served_r;
        end
    end
`else
    // Winner selection: data always wins over fetch.
    always_comb begin
        pick_d_s = d_req;
    end
`endif

    // Next-state and next-request-field logic; inputs are only sampled in IDLE.
    always_comb begin
        state_s     = state_r;
        owner_s     = owner_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        mem_wstrb_s = mem_wstrb_r;
        case (state_r)
            ST_IDLE: begin
                if (d_req || if_req) begin
                    state_s   = ST_WAIT_GNT;
                    mem_req_s = 1'b1;
                    if (pick_d_s) begin
                        owner_s     = OWNER_D;
                        mem_we_s    = d_we;
                        mem_addr_s  = d_addr;
                        mem_wdata_s = d_wdata;
                        mem_wstrb_s = d_wstrb;
                    end else begin
                        // Fetches are always reads with no byte enables.
                        owner_s     = OWNER_F;
                        mem_we_s    = 1'b0;
                        mem_addr_s  = if_addr;
                        mem_wdata_s = '0;
                        mem_wstrb_s = '0;
                    end
                end else begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                end
            end
            ST_WAIT_GNT: begin
                if (mem_gnt) begin
                    state_s   = ST_WAIT_RSP;
                    mem_req_s = 1'b0;
                end else begin
                    state_s   = ST_WAIT_GNT;
                    mem_req_s = 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                mem_req_s = 1'b0;
                if (mem_rvalid) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_WAIT_RSP;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                mem_req_s = 1'b0;
            end
        endcase
    end

    // State, owner and memory request registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            owner_r     <= OWNER_F;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_wstrb_r <= '0;
        end else begin
            state_r     <= state_s;
            owner_r     <= owner_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            mem_wstrb_r <= mem_wstrb_s;
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign mem_wstrb = mem_wstrb_r;

    // Completion is signalled in the same cycle as mem_rvalid so the
    // requesting stage can advance without an extra bubble.
    assign if_valid = rsp_done_s && (owner_r == OWNER_F);
    assign d_valid  = rsp_done_s && (owner_r == OWNER_D);
    assign if_rdata = mem_rdata;
    assign d_rdata  = mem_rdata;

    assign stall_fetch = if_req && !if_valid;
    assign stall_mem   = d_req && !d_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Expected responses are queued as
// stimulus is issued; a monitor process pops and compares them whenever the
// DUT raises if_valid or d_valid.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        stall_fetch;
    logic        stall_mem;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .stall_fetch(stall_fetch), .stall_mem(stall_mem)
    );

    typedef struct {
        logic        is_d;
        logic        chk_data;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   if_cnt = 0;
    int   d_cnt = 0;
    int   cyc_cnt = 0;
    int   last_if_valid_cyc = 0;
    int   first_req_cyc = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc_cnt = cyc_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic is_d, input logic chk_data, input logic [31:0] rdata);
        exp_t e;
        e.is_d = is_d;
        e.chk_data = chk_data;
        e.rdata = rdata;
        exp_q.push_back(e);
    endtask

    // Drive point: just after the active edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Memory responder for one transaction: waits for mem_req, holds gnt low
    // for gdly cycles while checking the fields, grants, waits rdly cycles,
    // then returns rvalid. Exits at the drive point of the next IDLE cycle.
    task automatic serve(input int gdly, input int rdly, input logic [31:0] rdata,
                         input logic [31:0] eaddr, input logic ewe, input logic [3:0] estrb,
                         input logic [31:0] ewdata, input logic mutate);
        int n;
        n = 0;
        while (mem_req !== 1'b1 && n < 16) begin
            cyc();
            @(negedge clk);
            n = n + 1;
        end
        if (mem_req !== 1'b1) begin
            chk("mem_req_timeout", mem_req, 1'b1);
        end else begin
            first_req_cyc = cyc_cnt;
            for (int i = 0; i <= gdly; i++) begin
                if (i > 0) begin
                    cyc();
                    @(negedge clk);
                end
                chk("mem_req_hold", mem_req, 1'b1);
                chk("mem_addr", mem_addr, eaddr);
                chk("mem_we", mem_we, ewe);
                chk("mem_wstrb", mem_wstrb, estrb);
                if (ewe) chk("mem_wdata", mem_wdata, ewdata);
                if (mutate && i == 0) begin
                    d_addr  = ~d_addr;
                    d_wdata = ~d_wdata;
                    d_we    = ~d_we;
                    d_wstrb = ~d_wstrb;
                    if_addr = ~if_addr;
                end
            end
            mem_gnt = 1'b1;
            cyc();
            mem_gnt = 1'b0;
            for (int i = 0; i < rdly; i++) begin
                @(negedge clk);
                chk("mem_req_drop", mem_req, 1'b0);
                cyc();
            end
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            @(negedge clk);
            chk("mem_req_rsp", mem_req, 1'b0);
            cyc();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
    endtask

    // Monitor: stall definitions, valid exclusivity, and scoreboard pops.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("stall_fetch", stall_fetch, if_req & ~if_valid);
                chk("stall_mem", stall_mem, d_req & ~d_valid);
                chk("valid_exclusive", if_valid & d_valid, 1'b0);
                if (if_valid || d_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", {if_valid, d_valid}, 2'b00);
                    end else begin
                        e = exp_q.pop_front();
                        chk("resp_owner_d", d_valid, e.is_d);
                        if (e.chk_data) chk("resp_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                    end
                    if (if_valid) begin
                        if_cnt = if_cnt + 1;
                        last_if_valid_cyc = cyc_cnt;
                    end
                    if (d_valid) d_cnt = d_cnt + 1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int v1;
        reset_n = 1'b0; if_req = 1'b0; if_addr = 32'h0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0; d_wstrb = 4'h0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_wstrb", mem_wstrb, 4'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_if_valid", if_valid, 1'b0);
        chk("rst_d_valid", d_valid, 1'b0);
        chk("rst_stall_fetch_lo", stall_fetch, 1'b0);
        if_req = 1'b1;
        #1 chk("rst_stall_fetch_hi", stall_fetch, 1'b1);
        if_req = 1'b0;
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_mem_req", mem_req, 1'b0);

        // Single fetch
        cyc();
        if_req = 1'b1; if_addr = 32'h100;
        @(negedge clk);
        chk("fetch_t0_mem_req", mem_req, 1'b0);
        push_exp(1'b0, 1'b1, 32'h00500093);
        serve(0, 1, 32'h00500093, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0);
        if_req = 1'b0;
        @(negedge clk);
        chk("fetch_count", if_cnt, 1);
        chk("fetch_idle_mem_req", mem_req, 1'b0);

        // Store with delayed grant; inputs scrambled after capture
        cyc();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
        push_exp(1'b1, 1'b0, 32'h0);
        serve(3, 0, 32'h0, 32'h2000, 1'b1, 4'hF, 32'hDEADBEEF, 1'b1);
        d_req = 1'b0; d_we = 1'b0; d_wstrb = 4'h0;
        @(negedge clk);
        chk("store_count", d_cnt, 1);

        // Contention: both requests rise together
        cyc();
        if_req = 1'b1; if_addr = 32'h300;
        d_req = 1'b1; d_addr = 32'h400; d_we = 1'b0;
        @(negedge clk);
        chk("cont_stall_fetch", stall_fetch, 1'b1);
        chk("cont_stall_mem", stall_mem, 1'b1);
`ifdef MEMARB_ROUND_ROBIN_EN
        push_exp(1'b0, 1'b1, 32'h22222222);
        serve(0, 0, 32'h22222222, 32'h300, 1'b0, 4'h0, 32'h0, 1'b0);
        if_req = 1'b0;
        push_exp(1'b1, 1'b1, 32'h11111111);
        serve(1, 0, 32'h11111111, 32'h400, 1'b0, 4'h0, 32'h0, 1'b0);
        d_req = 1'b0;
`else
        push_exp(1'b1, 1'b1, 32'h11111111);
        serve(0, 0, 32'h11111111, 32'h400, 1'b0, 4'h0, 32'h0, 1'b0);
        d_req = 1'b0;
        push_exp(1'b0, 1'b1, 32'h22222222);
        serve(1, 0, 32'h22222222, 32'h300, 1'b0, 4'h0, 32'h0, 1'b0);
        if_req = 1'b0;
`endif

        // Back-to-back fetch with if_req held high
        cyc();
        if_req = 1'b1; if_addr = 32'h100;
        push_exp(1'b0, 1'b1, 32'hAAAA0001);
        push_exp(1'b0, 1'b1, 32'hAAAA0002);
        serve(0, 0, 32'hAAAA0001, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0);
        v1 = last_if_valid_cyc;
        if_addr = 32'h104;
        serve(0, 0, 32'hAAAA0002, 32'h104, 1'b0, 4'h0, 32'h0, 1'b0);
        if_req = 1'b0;
        chk("b2b_gap", first_req_cyc - v1, 2);
        @(negedge clk);
        chk("b2b_count", if_cnt, 4);

        // Spurious rvalid/gnt in IDLE, spurious rvalid in WAIT_GNT
        cyc();
        mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        chk("spur_idle_if_valid", if_valid, 1'b0);
        chk("spur_idle_d_valid", d_valid, 1'b0);
        chk("spur_idle_mem_req", mem_req, 1'b0);
        cyc();
        mem_rvalid = 1'b0; mem_gnt = 1'b0;
        @(negedge clk);
        chk("spur_idle_after", mem_req, 1'b0);
        cyc();
        d_req = 1'b1; d_addr = 32'h500;
        @(negedge clk);
        cyc();
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("spur_gnt_mem_req", mem_req, 1'b1);
        chk("spur_gnt_d_valid", d_valid, 1'b0);
        cyc();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("spur_gnt_state", mem_req, 1'b1);
        push_exp(1'b1, 1'b1, 32'h33333333);
        serve(0, 0, 32'h33333333, 32'h500, 1'b0, 4'h0, 32'h0, 1'b0);
        d_req = 1'b0;

        // Reset while waiting for grant: mem_req drops asynchronously
        cyc();
        d_req = 1'b1; d_addr = 32'h680;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("rstg_mem_req_before", mem_req, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk("rstg_mem_req_async", mem_req, 1'b0);
        d_req = 1'b0;
        cyc();
        reset_n = 1'b1;

        // Reset while waiting for response, then a late rvalid
        cyc();
        d_req = 1'b1; d_addr = 32'h600;
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("rstr_mem_req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("rstr_wait_rsp", mem_req, 1'b0);
        #2 mem_rvalid = 1'b1; mem_rdata = 32'h55555555; reset_n = 1'b0;
        #1 chk("rstr_d_valid", d_valid, 1'b0);
        chk("rstr_if_valid", if_valid, 1'b0);
        chk("rstr_mem_req", mem_req, 1'b0);
        cyc();
        reset_n = 1'b1;
        @(negedge clk);
        chk("late_rvalid_d_valid", d_valid, 1'b0);
        chk("late_rvalid_if_valid", if_valid, 1'b0);
        cyc();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        d_req = 1'b1; d_addr = 32'h700; d_we = 1'b0;
        push_exp(1'b1, 1'b1, 32'h44444444);
        serve(0, 0, 32'h44444444, 32'h700, 1'b0, 4'h0, 32'h0, 1'b0);
        d_req = 1'b0;

        repeat (3) begin
            cyc();
            @(negedge clk);
        end
        chk("queue_empty", exp_q.size(), 0);
        chk("total_if_valid", if_cnt, 4);
        chk("total_d_valid", d_cnt, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory port between the fetch stage (F) and the memory stage (D).
- One outstanding transaction at a time; the memory side uses a req/gnt request handshake followed by an rvalid response.
- Produces per-stage stall requests, which the hazard logic ORs into StallF and the pipeline-wide stall.

Parameters:
ADDR_W, 32, address width of both requesters and the memory port
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request, level; held until if_valid
if_addr  in  ADDR_W  fetch address
if_rdata  out  DATA_W  fetch read data, meaningful only when if_valid
if_valid  out  1  fetch transaction complete (single cycle)
d_req  in  1  data request, level; held until d_valid
d_we  in  1  1 = store, 0 = load
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_wstrb  in  DATA_W/8  store byte enables
d_rdata  out  DATA_W  load data, meaningful only when d_valid
d_valid  out  1  data transaction complete (single cycle)
mem_req  out  1  request to memory
mem_we  out  1  write enable
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_wstrb  out  DATA_W/8  byte enables; all-zero for reads
mem_gnt  in  1  memory accepted the request this cycle
mem_rvalid  in  1  response / write acknowledge
mem_rdata  in  DATA_W  read data
stall_fetch  out  1  if_req & ~if_valid
stall_mem  out  1  d_req & ~d_valid

Behaviour:
- States: IDLE, WAIT_GNT, WAIT_RSP. Owner register: F or D.
- Reset (asynchronous, reset_n=0):
  - state=IDLE, owner=F, mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - if_valid=d_valid=0.
  - Stall outputs follow their combinational definitions.
- IDLE:
  - If d_req is pending, select D; otherwise if if_req is pending, select F (fixed data priority).
  - On a selection: latch owner, addr, we, wdata and wstrb into the mem_* registers. For F, we=0 and wstrb=0.
  - Next cycle: state=WAIT_GNT, mem_req=1.
  - No request pending: stay in IDLE with mem_req=0.
- WAIT_GNT:
  - mem_req=1 and all mem_* fields held stable.
  - mem_gnt=1 moves to WAIT_RSP and drops mem_req in that next cycle.
- WAIT_RSP:
  - When mem_rvalid=1, the owner's valid output is driven combinationally this cycle and the owner's rdata = mem_rdata. Next state is IDLE.
  - Stores also complete on rvalid; d_rdata is don't-care for stores.
- Valid outputs:
  - if_valid = (state==WAIT_RSP) & owner==F & mem_rvalid.
  - d_valid = (state==WAIT_RSP) & owner==D & mem_rvalid.
  - Never both set in the same cycle.
- Minimum latency:
  - req at cycle t (IDLE), mem_req at t+1.
  - gnt at t+1 gives WAIT_RSP at t+2.
  - rvalid at t+2 gives valid at t+2; back in IDLE and re-arbitrating at t+3.
- Request hold and capture:
  - Requesters may keep req high after valid to issue a back-to-back access; the new fields are sampled in IDLE at t+3.
  - Request inputs are sampled only in IDLE. Changes to them during WAIT_GNT or WAIT_RSP have no effect.
- Spurious responses:
  - mem_rvalid outside WAIT_RSP is ignored; no valid pulse is produced.
  - mem_gnt outside WAIT_GNT is ignored.
  - The memory guarantees rvalid no earlier than the cycle after gnt.
- Reset mid-transaction: the state machine returns to IDLE immediately and mem_req drops asynchronously. A late rvalid after reset release is ignored.
- Simultaneous if_req and d_req in IDLE: D wins, and F stalls (stall_fetch=1) until its own valid.

Optional Feature:
MEMARB_ROUND_ROBIN_EN
- Defined: a last_served flag (reset = D) is updated on each valid.
  - When both requests are pending in IDLE, the requester not last served wins.
  - A single pending request is always served.
- Undefined: fixed data-over-fetch priority as described in Behaviour, and no last_served register.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100; gnt on the first cycle of mem_req; rvalid 2 cycles later with rdata=0x00500093.
  - Expected: if_valid pulses one cycle with if_rdata=0x00500093.
  - Expected: mem_we=0 and mem_wstrb=0 throughout; stall_fetch=1 every cycle before the pulse.
- Store: d_req=1, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF; gnt delayed 3 cycles.
  - Expected: mem_req stays high for 4 cycles with the fields stable.
  - Expected: d_valid is set on rvalid.
- Contention: if_req and d_req both rise in the same IDLE cycle.
  - Expected (macro undefined): D is issued first; F is issued in IDLE after d_valid; stall_fetch=1 until if_valid.
  - Expected (macro defined, after a prior D access): F is issued first.
- Back-to-back fetch: if_req held high across two accesses, 0x100 then 0x104.
  - Expected: second mem_req appears exactly 2 cycles after the first if_valid.
  - Expected: exactly two if_valid pulses.
- Spurious response: mem_rvalid=1 pulsed while in IDLE and while in WAIT_GNT.
  - Expected: no if_valid or d_valid pulse; state unchanged.
- Reset mid-transaction: reset_n=0 asserted in WAIT_RSP.
  - Expected: mem_req=0 and valids=0 immediately.
  - Expected: an rvalid after reset release is ignored; a new d_req is then served normally.
